// File: rtl/s_ram_arb_pkg.sv
// s_ram_arb_pkg: shared types and sizing helpers for the s_ram arbiter.
package s_ram_arb_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

    localparam int NREQ_MIN = 2;
    localparam int NREQ_MAX = 8;

    function automatic bit nreq_ok(int n);
        return (n >= NREQ_MIN) && (n <= NREQ_MAX);
    endfunction

    function automatic int idx_w(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(int lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational winner select from req and last-winner pointer.
// With ARB_FIXED_PRIO_EN defined it is a plain lowest-index priority encoder.
module rr_picker
    import s_ram_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
`ifndef ARB_FIXED_PRIO_EN
    input  logic [IW-1:0]   ptr_i,
`endif
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o,
    output logic            any_o
);

    assign any_o = |req_i;
    assign gnt_o = any_o ? (NREQ'(1) << idx_o) : '0;

`ifdef ARB_FIXED_PRIO_EN
    always_comb begin
        idx_o = '0;
        for (int i = NREQ - 1; i >= 0; i--)
            if (req_i[i]) idx_o = IW'(i);
    end
`else
    logic [IW-1:0] c;
    logic          found;

    // Search starts just after the previous winner, so it gets lowest priority.
    always_comb begin
        idx_o = '0;
        found = 1'b0;
        c     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            c = IW'((int'(ptr_i) + k) % NREQ);
            if (!found && req_i[c]) begin
                found = 1'b1;
                idx_o = c;
            end
        end
    end
`endif

endmodule

// File: rtl/s_ram_arbiter.sv
// s_ram_arbiter: shares one single-port s_ram between NREQ req/gnt requesters, one access in flight.
// Round-robin by default; define ARB_FIXED_PRIO_EN for fixed lowest-index priority.
module s_ram_arbiter
    import s_ram_arb_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int AW     = 4,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [NREQ-1:0]    req_i,
    input  logic [NREQ-1:0]    we_i,
    input  logic [NREQ*AW-1:0] addr_i,
    input  logic [NREQ*DW-1:0] wdata_i,
    output logic [NREQ-1:0]    gnt_o,
    output logic [NREQ-1:0]    rvalid_o,
    output logic [DW-1:0]      rdata_o,
    output logic               ram_en_o,
    output logic [AW-1:0]      ram_addr_o,
    output logic [DW-1:0]      ram_data_in_o,
    input  logic [DW-1:0]      ram_data_out_i
);

    localparam int IW = idx_w(NREQ);
    localparam int CW = cnt_w(RD_LAT);

    state_e          state_q, state_d;
    logic [NREQ-1:0] win_q, win_d, gnt_q, gnt_d, rvalid_q, rvalid_d, pick;
    logic [IW-1:0]   pick_idx;
    logic            pick_any, ram_en_q, ram_en_d;
    logic [AW-1:0]   ram_addr_q, ram_addr_d;
    logic [DW-1:0]   ram_data_in_q, ram_data_in_d, rdata_q, rdata_d;
    logic [CW-1:0]   cnt_q, cnt_d;
`ifndef ARB_FIXED_PRIO_EN
    logic [IW-1:0]   ptr_q, ptr_d;
`endif

    rr_picker #(.NREQ(NREQ), .IW(IW)) u_picker (
        .req_i (req_i),
`ifndef ARB_FIXED_PRIO_EN
        .ptr_i (ptr_q),
`endif
        .gnt_o (pick),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // RAM drive and gnt are loaded on the IDLE edge so they are valid for the whole ISSUE cycle.
    always_comb begin
        state_d       = state_q;
        win_d         = win_q;
        gnt_d         = '0;
        rvalid_d      = '0;
        ram_en_d      = 1'b0;
        ram_addr_d    = ram_addr_q;
        ram_data_in_d = ram_data_in_q;
        rdata_d       = rdata_q;
        cnt_d         = cnt_q;
`ifndef ARB_FIXED_PRIO_EN
        ptr_d         = ptr_q;
`endif
        unique case (state_q)
            IDLE: if (pick_any) begin
                state_d       = ISSUE;
                win_d         = pick;
                gnt_d         = pick;
                ram_en_d      = we_i[pick_idx];
                ram_addr_d    = addr_i[pick_idx*AW +: AW];
                ram_data_in_d = wdata_i[pick_idx*DW +: DW];
`ifndef ARB_FIXED_PRIO_EN
                ptr_d         = pick_idx;
`endif
            end
            ISSUE: begin
                state_d = ram_en_q ? IDLE : WAIT;
                cnt_d   = '0;
            end
            WAIT: if (cnt_q == CW'(RD_LAT - 1)) begin
                state_d  = IDLE;
                rdata_d  = ram_data_out_i;
                rvalid_d = win_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            win_q         <= '0;
            gnt_q         <= '0;
            rvalid_q      <= '0;
            ram_en_q      <= 1'b0;
            ram_addr_q    <= '0;
            ram_data_in_q <= '0;
            rdata_q       <= '0;
            cnt_q         <= '0;
`ifndef ARB_FIXED_PRIO_EN
            ptr_q         <= IW'(NREQ - 1);
`endif
        end else begin
            state_q       <= state_d;
            win_q         <= win_d;
            gnt_q         <= gnt_d;
            rvalid_q      <= rvalid_d;
            ram_en_q      <= ram_en_d;
            ram_addr_q    <= ram_addr_d;
            ram_data_in_q <= ram_data_in_d;
            rdata_q       <= rdata_d;
            cnt_q         <= cnt_d;
`ifndef ARB_FIXED_PRIO_EN
            ptr_q         <= ptr_d;
`endif
        end
    end

    assign gnt_o         = gnt_q;
    assign rvalid_o      = rvalid_q;
    assign rdata_o       = rdata_q;
    assign ram_en_o      = ram_en_q;
    assign ram_addr_o    = ram_addr_q;
    assign ram_data_in_o = ram_data_in_q;

endmodule

// File: tb/tb_s_ram_arbiter.sv
// tb_s_ram_arbiter: directed and random checks of s_ram_arbiter against a transaction-level model.
module tb_s_ram_arbiter;

    localparam int N   = 3;
    localparam int AW  = 4;
    localparam int DW  = 8;
    localparam int RDL = 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req = '0, we = '0;
    logic [N*AW-1:0] addr = '0;
    logic [N*DW-1:0] wdata = '0;
    logic [N-1:0]    gnt, rvalid;
    logic [DW-1:0]   rdata, ram_data_in;
    logic            ram_en;
    logic [AW-1:0]   ram_addr;
    logic [DW-1:0]   ram_dout = '0;
    logic [DW-1:0]   ram [16] = '{default: '0};

    always #5 clk = ~clk;

    s_ram_arbiter #(.NREQ(N), .AW(AW), .DW(DW), .RD_LAT(RDL)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .req_i          (req),
        .we_i           (we),
        .addr_i         (addr),
        .wdata_i        (wdata),
        .gnt_o          (gnt),
        .rvalid_o       (rvalid),
        .rdata_o        (rdata),
        .ram_en_o       (ram_en),
        .ram_addr_o     (ram_addr),
        .ram_data_in_o  (ram_data_in),
        .ram_data_out_i (ram_dout)
    );

    // Stand-in for the s_ram instance: write when en=1, otherwise registered read.
    always @(posedge clk) begin
        if (ram_en) ram[ram_addr] <= ram_data_in;
        else ram_dout <= ram[ram_addr];
    end

    int checks = 0, passed = 0;
    int m_ptr, m_busy, rv_cnt, rv_who, last_w;
    logic [DW-1:0] exp_mem [16] = '{default: '0};
    logic [DW-1:0] rv_data, exp_rdata, rv_last;
    int gnt_seen [N], rv_seen [N];
    int glog [$];

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int pick(logic [N-1:0] r);
`ifdef ARB_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) if (r[i]) return i;
`else
        for (int k = 1; k <= N; k++) if (r[(m_ptr + k) % N]) return (m_ptr + k) % N;
`endif
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = N - 1; m_busy = 0; rv_cnt = 0; exp_rdata = '0; last_w = -1;
    endtask

    task automatic clear_stats();
        for (int i = 0; i < N; i++) begin gnt_seen[i] = 0; rv_seen[i] = 0; end
        glog.delete();
    endtask

    task automatic set_req(int i, logic w, logic [AW-1:0] a, logic [DW-1:0] d);
        req[i] = 1'b1; we[i] = w; addr[i*AW +: AW] = a; wdata[i*DW +: DW] = d;
    endtask

    task automatic clr_req(int i);
        req[i] = 1'b0;
    endtask

    // One clock: predict from the inputs about to be sampled, then compare just after the edge.
    task automatic cycle();
        int w;
        logic [N-1:0] eg, erv;
        logic een;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        w = -1; eg = '0; erv = '0; een = 1'b0; ea = '0; ed = '0;
        if (rv_cnt > 0) begin
            rv_cnt--;
            if (rv_cnt == 0) begin erv = N'(1) << rv_who; exp_rdata = rv_data; end
        end
        if (m_busy > 0) m_busy--;
        else if (req != '0) begin
            w = pick(req);
            eg = N'(1) << w; een = we[w]; ea = addr[w*AW +: AW]; ed = wdata[w*DW +: DW];
            m_ptr = w;
            if (een) begin exp_mem[ea] = ed; m_busy = 1; end
            else begin rv_cnt = 1 + RDL; rv_who = w; rv_data = exp_mem[ea]; m_busy = 1 + RDL; end
        end
        @(posedge clk); #1;
        check("gnt", 32'(gnt), 32'(eg));
        check("rvalid", 32'(rvalid), 32'(erv));
        check("rdata", 32'(rdata), 32'(exp_rdata));
        check("ram_en", 32'(ram_en), 32'(een));
        if (w >= 0) begin
            check("ram_addr", 32'(ram_addr), 32'(ea));
            if (een) check("ram_data_in", 32'(ram_data_in), 32'(ed));
            glog.push_back(w);
        end
        for (int i = 0; i < N; i++) begin
            gnt_seen[i] += int'(gnt[i]);
            rv_seen[i]  += int'(rvalid[i]);
        end
        if (rvalid != '0) rv_last = rdata;
        last_w = w;
    endtask

    // Run n clocks; a granted requester either drops its req or re-requests a random write.
    task automatic run(int n, bit refill);
        for (int c = 0; c < n; c++) begin
            cycle();
            if (last_w >= 0) begin
                if (refill) set_req(last_w, 1'b1, AW'($urandom), DW'($urandom));
                else clr_req(last_w);
            end
        end
    endtask

    task automatic do_reset();
        req = '0;
        rst_n = 1'b0;
        #1;
        check("rst_gnt", 32'(gnt), 0);
        check("rst_rvalid", 32'(rvalid), 0);
        check("rst_rdata", 32'(rdata), 0);
        check("rst_ram_en", 32'(ram_en), 0);
        check("rst_ram_addr", 32'(ram_addr), 0);
        check("rst_ram_data_in", 32'(ram_data_in), 0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        model_reset();
        clear_stats();
        #2;
        do_reset();

        // Contention: two held writers alternate from a fresh pointer.
        set_req(0, 1'b1, 4'h1, 8'h10);
        set_req(1, 1'b1, 4'h2, 8'h20);
        run(8, 1'b1);
        req = '0;
        check("t3_count", glog.size(), 4);
        for (int i = 0; i < 4 && i < glog.size(); i++)
`ifdef ARB_FIXED_PRIO_EN
            check("t3_order", glog[i], 0);
`else
            check("t3_order", glog[i], i % 2);
`endif
        run(4, 1'b0);

        // Single write then read of the same address by requester 0.
        clear_stats();
        set_req(0, 1'b1, 4'h3, 8'hA5);
        run(2, 1'b0);
        set_req(0, 1'b0, 4'h3, 8'h00);
        run(1, 1'b0);
        check("t2_gnt0", gnt_seen[0], 2);
        run(2, 1'b0);
        check("t2_rvalid0", rv_seen[0], 1);
        check("t2_rdata", 32'(rv_last), 32'hA5);

        // Read routing: requester 1 reads 3C while requester 0 writes elsewhere.
        set_req(0, 1'b1, 4'h7, 8'h3C);
        run(2, 1'b0);
        clear_stats();
        set_req(1, 1'b0, 4'h7, 8'h00);
        set_req(0, 1'b1, 4'h9, 8'h55);
        run(8, 1'b0);
        check("t4_rvalid1", rv_seen[1], 1);
        check("t4_rvalid0", rv_seen[0], 0);
        check("t4_rdata", 32'(rv_last), 32'h3C);

        // Withdrawn request: req1 only high during req0's ISSUE cycle.
        clear_stats();
        set_req(0, 1'b1, 4'h2, 8'h11);
        cycle();
        clr_req(0);
        set_req(1, 1'b1, 4'h4, 8'h22);
        cycle();
        clr_req(1);
        run(4, 1'b0);
        check("t6_gnt0", gnt_seen[0], 1);
        check("t6_gnt1", gnt_seen[1], 0);

        // Wrap: three held writers after reset.
        do_reset();
        clear_stats();
        for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(i), DW'(8'h40 + i));
        run(8, 1'b1);
        req = '0;
        check("t5_count", glog.size(), 4);
        for (int i = 0; i < 4 && i < glog.size(); i++)
`ifdef ARB_FIXED_PRIO_EN
            check("t5_order", glog[i], 0);
`else
            check("t5_order", glog[i], i % 3);
`endif
        run(4, 1'b0);

        // Reset mid-WAIT: outstanding read is abandoned.
        set_req(2, 1'b0, 4'h5, 8'h00);
        cycle();
        clr_req(2);
        cycle();
        #2;
        do_reset();
        clear_stats();
        run(5, 1'b0);
        check("t1_no_rvalid", rv_seen[0] + rv_seen[1] + rv_seen[2], 0);

        // Random traffic with withdrawals.
        for (int c = 0; c < 400; c++) begin
            cycle();
            for (int i = 0; i < N; i++) begin
                if (last_w == i) begin
                    if ($urandom_range(1) == 1) set_req(i, 1'($urandom), AW'($urandom), DW'($urandom));
                    else clr_req(i);
                end else if (req[i] && $urandom_range(15) == 0) clr_req(i);
                else if (!req[i] && $urandom_range(2) == 0) set_req(i, 1'($urandom), AW'($urandom), DW'($urandom));
            end
        end
        req = '0;
        run(6, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
